// File: rtl/conv1_window_gen.sv
// 3x3x3 sliding-window generator: turns a raster pixel stream into stride-1,
// unpadded conv windows using two line buffers and a 3-column shift window.
module conv1_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pixel_valid,
  input  logic [23:0]  pixel_data,
  output logic         valid,
  output logic [215:0] input_act,
  output logic [9:0]   win_x,
  output logic [9:0]   win_y,
  output logic         frame_done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

  logic [9:0]  x;
  logic [9:0]  y;
  logic [23:0] lb1 [IMG_W];  // row y-1
  logic [23:0] lb2 [IMG_W];  // row y-2
  logic [23:0] sw  [3][3];   // shift window, [column][row], column 2 newest
  logic [23:0] nc  [3];      // column formed by the incoming pixel
  logic [AW-1:0] xi;
  logic          accept;
  logic          emit;
  logic [215:0]  act_next;

  assign xi     = x[AW-1:0];
  assign accept = pixel_valid && !rst;
  assign emit   = (x >= 10'd2) && (y >= 10'd2);
  assign nc[0]  = lb2[xi];
  assign nc[1]  = lb1[xi];
  assign nc[2]  = pixel_data;

  // Window columns after this pixel's shift: sw[1], sw[2], then the new column.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar col = 0; col < 3; col++) begin : g_col
        if (col == 2) begin : g_new
          assign act_next[72*c + 8*(3*r + col) +: 8] = nc[r][8*c +: 8];
        end else begin : g_old
          assign act_next[72*c + 8*(3*r + col) +: 8] = sw[col+1][r][8*c +: 8];
        end
      end
    end
  end

  // Line buffers are always rewritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[xi] <= lb1[xi];
      lb1[xi] <= pixel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      input_act  <= '0;
      win_x      <= '0;
      win_y      <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          sw[i][j] <= '0;
    end else begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
      if (pixel_valid) begin
        for (int j = 0; j < 3; j++) begin
          sw[0][j] <= sw[1][j];
          sw[1][j] <= sw[2][j];
          sw[2][j] <= nc[j];
        end
        if (emit) begin
          valid      <= 1'b1;
          input_act  <= act_next;
          win_x      <= x - 10'd2;
          win_y      <= y - 10'd2;
          frame_done <= (x == X_LAST) && (y == Y_LAST);
        end
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? 10'd0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

endmodule

// File: doc/conv1_window_gen.md
CONV1_WINDOW_GEN -- requirements
Module: conv1_window_gen

Interface
REQ-001 Parameter IMG_W, default 8: pixels per image row; legal range 3..1024.
REQ-002 Parameter IMG_H, default 6: rows per image; legal range 3..1024.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pixel_valid  input  1  pixel_data carries one pixel this cycle.
REQ-006 pixel_data  input  24  one pixel, three channels; channel c in bits [8c+7:8c], signed 8-bit.
REQ-007 valid  output  1  input_act holds a complete 3x3x3 window this cycle; drives the conv stage valid input.
REQ-008 input_act  output  216  window payload for the conv stage.
REQ-009 win_x  output  10  output-column index of the current window.
REQ-010 win_y  output  10  output-row index of the current window.
REQ-011 frame_done  output  1  pulses with the last window of a frame.

Function
REQ-012 Pixels SHALL arrive in raster order (x = 0..IMG_W-1 within a row, rows y = 0..IMG_H-1); the block SHALL always accept a pixel and needs no input stall.
REQ-013 Gaps SHALL be legal: with pixel_valid=0, all counters, buffers and window registers hold, and valid=0.
REQ-014 Column counter x and row counter y SHALL advance once per accepted pixel; x wraps IMG_W-1->0 with y+1; at (IMG_W-1, IMG_H-1) both wrap to 0 for the next frame.
REQ-015 Two line buffers of depth IMG_W SHALL hold rows y-1 and y-2, indexed by x; on each accepted pixel, row y-2 at x takes row y-1 at x, and row y-1 at x takes pixel_data.
REQ-016 A 3-column shift window SHALL shift one column per accepted pixel; the new column is {row y-2[x], row y-1[x], pixel_data}.
REQ-017 A window SHALL be emitted when an accepted pixel has x>=2 and y>=2; it covers rows y-2..y and columns x-2..x (stride 1, no padding).
REQ-018 Output latency SHALL be exactly 1 cycle: valid, input_act, win_x, win_y and frame_done are registered and asserted the cycle after the completing pixel is sampled.
REQ-019 valid SHALL be a single-cycle pulse per window; there is no backpressure and back-to-back windows on consecutive cycles are legal.
REQ-020 input_act layout: fmap c = input_act[72c+71:72c]; within fmap c, tap k = 3*r + col (r = 0 top row, col = 0 left column) at bits [8k+7:8k], taken from channel c of that pixel.
REQ-021 win_x SHALL be x-2 and win_y SHALL be y-2 of the completing pixel.
REQ-022 frame_done SHALL assert together with valid for window (IMG_W-3, IMG_H-3) only.
REQ-023 Windows per frame SHALL be exactly (IMG_W-2)*(IMG_H-2).
REQ-024 Windows SHALL never span a row or frame boundary: line-buffer and shift contents from a previous row or frame are never emitted, because emission requires x>=2 and y>=2 in the current frame.
REQ-025 input_act, win_x and win_y SHALL hold their last values while valid=0.

Reset
REQ-026 While rst=1 at a clock edge: x, y <- 0; valid, frame_done <- 0; input_act, win_x, win_y <- 0; shift-window registers <- 0.
REQ-027 Line-buffer contents need not be reset; by REQ-024 they are always overwritten before use.
REQ-028 A reset asserted mid-frame SHALL abandon the frame; the first pixel accepted after rst deasserts is pixel (0,0) of a new frame.
REQ-029 A pixel presented in the same cycle as rst=1 SHALL be discarded.

Verification (IMG_W=8, IMG_H=6; pixel value p(x,y) = 8y + x in all three channels)
REQ-030 Contiguous frame, one pixel per cycle -> first valid one cycle after pixel index 18 (2,2) with win_x=0, win_y=0; fmap0 tap0 = 0x00, tap4 = 0x09, tap8 = 0x12; all three fmaps identical.
REQ-031 Same frame -> exactly 24 valid pulses; the last has win_x=5, win_y=3, tap8 = 0x2F and frame_done=1; frame_done stays 0 on every other cycle.
REQ-032 Random pixel_valid gaps (about 50% duty) -> the same 24 windows in the same order with the same payloads as REQ-030/031; valid never high on a cycle that does not follow an accepted completing pixel.
REQ-033 Two frames back-to-back with no idle cycle -> 48 windows total; the first window of frame 2 again has win_x=0, win_y=0, tap0 = 0x00 with no frame-1 data in it.
REQ-034 rst pulsed for 1 cycle after pixel (4,3) -> no valid for the rest of that cycle; a fresh frame afterwards yields exactly 24 correct windows.
REQ-035 Row boundary check -> no window is emitted for completing pixels with x=0 or x=1 in any row y>=2.
